// File: rtl/udp_rx_chksum_input_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// udp_rx_chksum_input_ctrl_pkg
//
// Shared types and constants for the UDP RX checksum input stage:
//   - interface widths of the IP/MAC side (IP address, total length, MAC bus,
//     pad-byte count, packet timestamp)
//   - the 12-byte checksum pseudo-header layout and the UDP protocol number
//   - the per-packet tracker statistics carried on tuser
// ----------------------------------------------------------------------------
package udp_rx_chksum_input_ctrl_pkg;

   localparam int IP_ADDR_W           = 32;
   localparam int TOT_LEN_W           = 16;
   localparam int MAC_INTERFACE_W     = 256;
   localparam int MAC_INTERFACE_BYTES = MAC_INTERFACE_W / 8;
   localparam int MAC_PADBYTES_W      = $clog2(MAC_INTERFACE_BYTES);
   localparam int PKT_TIMESTAMP_W     = 64;

   localparam int CHKSUM_PSEUDO_HDR_BYTES = 12;
   localparam int CHKSUM_PSEUDO_HDR_W     = CHKSUM_PSEUDO_HDR_BYTES * 8;

   localparam logic [7:0] UDP_PROTOCOL = 8'd17;

   // Checksum pseudo-header, MSB-first on the wire.
   typedef struct packed {
      logic [IP_ADDR_W-1:0] src_ip;
      logic [IP_ADDR_W-1:0] dst_ip;
      logic [7:0]           zero_pad;
      logic [7:0]           protocol;
      logic [TOT_LEN_W-1:0] udp_len;
   } chksum_pseudo_hdr;

   // Per-packet statistics that travel alongside the packet on tuser.
   typedef struct packed {
      logic [PKT_TIMESTAMP_W-1:0] packet_timestamp;
   } tracker_stats_struct;

endpackage

// File: rtl/udp_rx_chksum_input_ctrl_data_masker.sv
// ----------------------------------------------------------------------------
// udp_rx_chksum_input_ctrl_data_masker
//
// Zeroes every byte of a beat whose keep bit is clear. Keep bit i qualifies
// data byte i (bits [8*i+7 : 8*i]), so an MSB-aligned keep clears the tail.
//
// Ports:
//   data_i  in   DATA_WIDTH  raw beat
//   keep_i  in   KEEP_WIDTH  byte enables
//   data_o  out  DATA_WIDTH  beat with disabled bytes forced to zero
// ----------------------------------------------------------------------------
module udp_rx_chksum_input_ctrl_data_masker #(
   parameter int DATA_WIDTH = 256,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [KEEP_WIDTH-1:0] keep_i,
   output logic [DATA_WIDTH-1:0] data_o
);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can
      // leave it unassigned and infer a latch.
      data_o = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         data_o[i*8 +: 8] = keep_i[i] ? data_i[i*8 +: 8] : 8'h00;
      end
   end

endmodule

// File: rtl/udp_rx_chksum_input_ctrl.sv
// ----------------------------------------------------------------------------
// udp_rx_chksum_input_ctrl
//
// Receive-side checksum input stage. Accepts a decoded UDP header and its
// payload stream and emits a single stream with the 12-byte checksum
// pseudo-header prepended, realigned into DATA_WIDTH beats.
//
// Optional feature (macro UDP_RX_CHKSUM_LEN_CHECK_EN): count the payload bytes
// actually received and raise the sticky len_err flag when the count at
// data_last differs from the header length. Without the macro, len_err is 0.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   src_udp_to_chksum_rx_hdr_*          header handshake, IPs, length, stats
//   src_udp_to_chksum_rx_data_*         payload beat, last, pad-byte count
//   udp_to_chksum_src_rx_{hdr,data}_rdy ready back to the header/payload side
//   req_t{data,keep,user,val,last}      output stream, req_trdy back-pressure
//   len_err                             sticky length-mismatch flag
// ----------------------------------------------------------------------------
module udp_rx_chksum_input_ctrl
   import udp_rx_chksum_input_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = MAC_INTERFACE_W,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int USER_WIDTH = PKT_TIMESTAMP_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      src_udp_to_chksum_rx_hdr_val,
   output logic                      udp_to_chksum_src_rx_hdr_rdy,
   input  logic [IP_ADDR_W-1:0]      src_udp_to_chksum_rx_src_ip,
   input  logic [IP_ADDR_W-1:0]      src_udp_to_chksum_rx_dst_ip,
   input  logic [TOT_LEN_W-1:0]      src_udp_to_chksum_rx_data_len,
   input  tracker_stats_struct       src_udp_to_chksum_rx_timestamp,
   input  logic                      src_udp_to_chksum_rx_data_val,
   output logic                      udp_to_chksum_src_rx_data_rdy,
   input  logic [DATA_WIDTH-1:0]     src_udp_to_chksum_rx_data,
   input  logic                      src_udp_to_chksum_rx_data_last,
   input  logic [MAC_PADBYTES_W-1:0] src_udp_to_chksum_rx_data_padbytes,
   output logic [DATA_WIDTH-1:0]     req_tdata,
   output logic [KEEP_WIDTH-1:0]     req_tkeep,
   output logic [USER_WIDTH-1:0]     req_tuser,
   output logic                      req_tval,
   input  logic                      req_trdy,
   output logic                      req_tlast,
   output logic                      len_err
);

   localparam int USE_BYTES  = CHKSUM_PSEUDO_HDR_BYTES;
   localparam int HOLD_BYTES = KEEP_WIDTH - USE_BYTES;
   localparam int USE_W      = USE_BYTES * 8;
   localparam int HOLD_W     = HOLD_BYTES * 8;
   // One extra bit so data_len + 12 never wraps.
   localparam int LEN_W      = TOT_LEN_W + 1;
   localparam logic [LEN_W-1:0] BEAT_BYTES = LEN_W'(KEEP_WIDTH);

   typedef enum logic [1:0] {IDLE, FIRST, STREAM, DRAIN} state_e;

   state_e              state_q, state_d;
   chksum_pseudo_hdr    hdr_q, hdr_d;
   tracker_stats_struct tuser_q, tuser_d;
   logic [USE_W-1:0]    hold_q, hold_d;
   logic [LEN_W-1:0]    bytes_left_q, bytes_left_d;

   logic                  last_fits;
   logic [LEN_W-1:0]      bytes_left_dec;
   logic [KEEP_WIDTH-1:0] tail_keep;
   logic [USE_W-1:0]      prefix;
   logic [DATA_WIDTH-1:0] raw_data;
   logic [KEEP_WIDTH-1:0] raw_keep;
   logic                  hdr_hs;
   logic                  data_hs;

   always_comb begin
      state_d      = state_q;
      hdr_d        = hdr_q;
      tuser_d      = tuser_q;
      hold_d       = hold_q;
      bytes_left_d = bytes_left_q;

      udp_to_chksum_src_rx_hdr_rdy  = 1'b0;
      udp_to_chksum_src_rx_data_rdy = 1'b0;
      req_tval  = 1'b0;
      req_tlast = 1'b0;
      prefix    = hold_q;
      raw_data  = '0;
      raw_keep  = '0;
      hdr_hs    = 1'b0;
      data_hs   = 1'b0;

      // Remaining bytes fit in the current beat; the count saturates at zero
      // so an over-long payload cannot wrap it.
      last_fits      = (bytes_left_q <= BEAT_BYTES);
      bytes_left_dec = last_fits ? '0 : bytes_left_q - BEAT_BYTES;
      // Top bytes_left bits set; a shift of the full width yields all ones.
      tail_keep      = ~({KEEP_WIDTH{1'b1}} >> bytes_left_q);

      case (state_q)
         IDLE: begin
            udp_to_chksum_src_rx_hdr_rdy = 1'b1;
            hdr_hs = src_udp_to_chksum_rx_hdr_val;
            if (hdr_hs) begin
               hdr_d = '{src_ip:   src_udp_to_chksum_rx_src_ip,
                         dst_ip:   src_udp_to_chksum_rx_dst_ip,
                         zero_pad: 8'h00,
                         protocol: UDP_PROTOCOL,
                         udp_len:  src_udp_to_chksum_rx_data_len};
               tuser_d      = src_udp_to_chksum_rx_timestamp;
               bytes_left_d = {1'b0, src_udp_to_chksum_rx_data_len} + LEN_W'(USE_BYTES);
               state_d      = FIRST;
            end
         end

         FIRST, STREAM: begin
            // Flow-through: the output beat is the input beat shifted down by
            // the 12 bytes still owed from the previous beat (or the header).
            req_tval  = src_udp_to_chksum_rx_data_val;
            udp_to_chksum_src_rx_data_rdy = req_trdy;
            req_tlast = src_udp_to_chksum_rx_data_last && last_fits;
            if (state_q == FIRST) begin
               prefix = hdr_q;
            end
            raw_data = {prefix, src_udp_to_chksum_rx_data[DATA_WIDTH-1 -: HOLD_W]};
            raw_keep = req_tlast ? tail_keep : '1;
            data_hs  = src_udp_to_chksum_rx_data_val && req_trdy;
            if (data_hs) begin
               hold_d = src_udp_to_chksum_rx_data[USE_W-1:0];
               if (!src_udp_to_chksum_rx_data_last) begin
                  bytes_left_d = bytes_left_dec;
                  state_d      = STREAM;
               end else if (last_fits) begin
                  state_d = IDLE;
               end else begin
                  // The held low bytes spill into one extra output beat.
                  bytes_left_d = bytes_left_dec;
                  state_d      = DRAIN;
               end
            end
         end

         DRAIN: begin
            req_tval  = 1'b1;
            req_tlast = 1'b1;
            raw_data  = {hold_q, {HOLD_W{1'b0}}};
            raw_keep  = tail_keep;
            if (req_trdy) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      if (!rst_n) begin
         state_q      <= IDLE;
         hdr_q        <= '0;
         tuser_q      <= '0;
         hold_q       <= '0;
         bytes_left_q <= '0;
      end else begin
         state_q      <= state_d;
         hdr_q        <= hdr_d;
         tuser_q      <= tuser_d;
         hold_q       <= hold_d;
         bytes_left_q <= bytes_left_d;
      end
   end

   udp_rx_chksum_input_ctrl_data_masker #(
      .DATA_WIDTH (DATA_WIDTH),
      .KEEP_WIDTH (KEEP_WIDTH)
   ) u_data_masker (
      .data_i (raw_data),
      .keep_i (raw_keep),
      .data_o (req_tdata)
   );

   assign req_tkeep = raw_keep;
   assign req_tuser = USER_WIDTH'(tuser_q);

`ifdef UDP_RX_CHKSUM_LEN_CHECK_EN
   logic [LEN_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [LEN_W-1:0] rx_total;
   logic             len_err_q, len_err_d;

   always_comb begin
      rx_cnt_d  = rx_cnt_q;
      len_err_d = len_err_q;
      // Byte count including the last beat, which is short by padbytes.
      rx_total  = rx_cnt_q + BEAT_BYTES - LEN_W'(src_udp_to_chksum_rx_data_padbytes);
      if (hdr_hs) begin
         rx_cnt_d = '0;
      end else if (data_hs) begin
         if (!src_udp_to_chksum_rx_data_last) begin
            rx_cnt_d = rx_cnt_q + BEAT_BYTES;
         end else if (rx_total != {1'b0, hdr_q.udp_len}) begin
            len_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_cnt_q  <= '0;
         len_err_q <= 1'b0;
      end else begin
         rx_cnt_q  <= rx_cnt_d;
         len_err_q <= len_err_d;
      end
   end

   assign len_err = len_err_q;
`else
   // Framing follows the header length alone, so padbytes has no consumer.
   logic unused_padbytes;
   assign unused_padbytes = ^src_udp_to_chksum_rx_data_padbytes;
   assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_udp_rx_chksum_input_ctrl.sv
// ----------------------------------------------------------------------------
// tb_udp_rx_chksum_input_ctrl
//
// Drives randomized UDP packets (random IPs, lengths, payload, pad garbage,
// source gaps and sink stalls) and compares every output beat against a byte-
// level model: output stream = pseudo-header bytes ++ payload bytes, cut into
// 32-byte beats, tail zeroed, keep MSB-aligned, tlast on the final beat.
// ----------------------------------------------------------------------------
module tb_udp_rx_chksum_input_ctrl;
   import udp_rx_chksum_input_ctrl_pkg::*;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic                      hdr_val;
   logic                      hdr_rdy;
   logic [IP_ADDR_W-1:0]      src_ip;
   logic [IP_ADDR_W-1:0]      dst_ip;
   logic [TOT_LEN_W-1:0]      data_len;
   tracker_stats_struct       ts_in;
   logic                      data_val;
   logic                      data_rdy;
   logic [255:0]              data_in;
   logic                      data_last;
   logic [MAC_PADBYTES_W-1:0] padbytes;
   logic [255:0]              req_tdata;
   logic [31:0]               req_tkeep;
   logic [63:0]               req_tuser;
   logic                      req_tval;
   logic                      req_trdy;
   logic                      req_tlast;
   logic                      len_err;

   int compared   = 0;
   int mismatched = 0;
   bit stall_en   = 1'b0;

   typedef struct {
      logic [255:0] data;
      logic [31:0]  keep;
      logic         last;
      logic [63:0]  user;
      logic         drain;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   udp_rx_chksum_input_ctrl dut (
      .clk                                (clk),
      .rst_n                              (rst_n),
      .src_udp_to_chksum_rx_hdr_val       (hdr_val),
      .udp_to_chksum_src_rx_hdr_rdy       (hdr_rdy),
      .src_udp_to_chksum_rx_src_ip        (src_ip),
      .src_udp_to_chksum_rx_dst_ip        (dst_ip),
      .src_udp_to_chksum_rx_data_len      (data_len),
      .src_udp_to_chksum_rx_timestamp     (ts_in),
      .src_udp_to_chksum_rx_data_val      (data_val),
      .udp_to_chksum_src_rx_data_rdy      (data_rdy),
      .src_udp_to_chksum_rx_data          (data_in),
      .src_udp_to_chksum_rx_data_last     (data_last),
      .src_udp_to_chksum_rx_data_padbytes (padbytes),
      .req_tdata                          (req_tdata),
      .req_tkeep                          (req_tkeep),
      .req_tuser                          (req_tuser),
      .req_tval                           (req_tval),
      .req_trdy                           (req_trdy),
      .req_tlast                          (req_tlast),
      .len_err                            (len_err)
   );

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Sink back-pressure, changed just after each rising edge.
   initial begin
      req_trdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         req_trdy = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Output monitor: a beat transfers at the next edge when val && rdy hold
   // at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && req_tval && req_trdy) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 256'(req_tval), 256'(0));
            end else begin
               e = exp_q.pop_front();
               check("tdata", req_tdata, e.data);
               check("tkeep", 256'(req_tkeep), 256'(e.keep));
               check("tlast", 256'(req_tlast), 256'(e.last));
               check("tuser", 256'(req_tuser), 256'(e.user));
               check("hdr_rdy_busy", 256'(hdr_rdy), 256'(0));
               if (e.drain) check("drain_data_rdy", 256'(data_rdy), 256'(0));
            end
         end
      end
   end

   task automatic send_hdr(input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] len, input logic [63:0] ts);
      bit hs;
      int n = 0;
      hdr_val  = 1'b1;
      src_ip   = s;
      dst_ip   = d;
      data_len = len;
      ts_in    = ts;
      do begin
         @(negedge clk);
         hs = hdr_rdy;
         @(posedge clk);
         #1;
         n++;
      end while (!hs && n < 200);
      if (!hs) check("hdr_timeout", 256'(hs), 256'(1));
      hdr_val = 1'b0;
   endtask

   task automatic send_beat(input logic [255:0] d, input logic l,
                            input logic [4:0] p, input bit gaps);
      bit hs;
      int n = 0;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      data_val  = 1'b1;
      data_in   = d;
      data_last = l;
      padbytes  = p;
      do begin
         @(negedge clk);
         hs = data_rdy;
         @(posedge clk);
         #1;
         n++;
      end while (!hs && n < 200);
      if (!hs) check("data_timeout", 256'(hs), 256'(1));
      data_val = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (exp_q.size() != 0) check("drain_timeout", 256'(exp_q.size()), 256'(0));
   endtask

   // One packet: len is the header length; nin_force > 0 sends that many full
   // beats regardless of len; abort_after > 0 stops after that many beats.
   task automatic run_pkt(input int len, input int nin_force, input bit gaps,
                          input int abort_after);
      logic [31:0]  s, d;
      logic [63:0]  ts;
      logic [95:0]  ph;
      logic [7:0]   pay[$];
      logic [7:0]   ob[$];
      logic [255:0] beat;
      exp_t         e;
      int nin, sent, total, nout, idx;

      s  = $urandom;
      d  = $urandom;
      ts = {$urandom, $urandom};
      nin  = (nin_force > 0) ? nin_force : (len + 31) / 32;
      sent = (nin_force > 0) ? nin * 32 : len;
      for (int i = 0; i < sent; i++) pay.push_back(8'($urandom));

      ph = {s, d, 8'h00, 8'd17, 16'(len)};
      for (int k = 0; k < 12; k++) ob.push_back(ph[95-8*k -: 8]);
      for (int i = 0; i < sent; i++) ob.push_back(pay[i]);

      total = len + 12;
      nout  = (total + 31) / 32;
      for (int b = 0; b < nout; b++) begin
         e.data = '0;
         e.keep = '0;
         for (int k = 0; k < 32; k++) begin
            idx = b * 32 + k;
            if (idx < total) begin
               e.data[255-8*k -: 8] = ob[idx];
               e.keep[31-k] = 1'b1;
            end
         end
         e.last  = (b == nout - 1);
         e.user  = ts;
         e.drain = (b >= nin);
         exp_q.push_back(e);
      end

      send_hdr(s, d, 16'(len), ts);
      for (int i = 0; i < nin; i++) begin
         if (abort_after > 0 && i == abort_after) return;
         for (int k = 0; k < 32; k++) begin
            idx = i * 32 + k;
            beat[255-8*k -: 8] = (idx < sent) ? pay[idx] : 8'($urandom);
         end
         send_beat(beat, (i == nin - 1), (i == nin - 1) ? 5'(nin * 32 - sent) : 5'd0, gaps);
      end
      wait_drain();
   endtask

   task automatic check_idle_outputs(input string pfx);
      check({pfx, "_hdr_rdy"}, 256'(hdr_rdy), 256'(1));
      check({pfx, "_data_rdy"}, 256'(data_rdy), 256'(0));
      check({pfx, "_tval"}, 256'(req_tval), 256'(0));
      check({pfx, "_tlast"}, 256'(req_tlast), 256'(0));
      check({pfx, "_tdata"}, req_tdata, 256'(0));
      check({pfx, "_tkeep"}, 256'(req_tkeep), 256'(0));
      check({pfx, "_tuser"}, 256'(req_tuser), 256'(0));
   endtask

   initial begin
      hdr_val   = 1'b0;
      src_ip    = '0;
      dst_ip    = '0;
      data_len  = '0;
      ts_in     = '0;
      data_val  = 1'b0;
      data_in   = '0;
      data_last = 1'b0;
      padbytes  = '0;

      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      check("reset_len_err", 256'(len_err), 256'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Boundary lengths: single beat with/without full keep, spill to DRAIN.
      run_pkt(8, 0, 1'b0, 0);
      run_pkt(20, 0, 1'b0, 0);
      run_pkt(21, 0, 1'b0, 0);
      stall_en = 1'b1;
      run_pkt(100, 0, 1'b1, 0);

      // Reset in the middle of a packet: partial packet dropped.
      stall_en = 1'b0;
      run_pkt(100, 0, 1'b0, 2);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_hdr_rdy", 256'(hdr_rdy), 256'(1));
      run_pkt(40, 0, 1'b0, 0);

      // Random traffic with stalls and source gaps.
      stall_en = 1'b1;
      repeat (40) run_pkt(int'($urandom_range(8, 300)), 0, 1'b1, 0);

`ifdef UDP_RX_CHKSUM_LEN_CHECK_EN
      check("len_err_clean", 256'(len_err), 256'(0));
      run_pkt(64, 3, 1'b1, 0);
      check("len_err_set", 256'(len_err), 256'(1));
      run_pkt(40, 0, 1'b1, 0);
      check("len_err_sticky", 256'(len_err), 256'(1));
`else
      check("len_err_off", 256'(len_err), 256'(0));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
